// File: rtl/uart_tx_fifo_rd_if.sv
// Read-side FIFO handshake and serial-line outputs of the UART1 transmitter.
// The master side is the transmitter: it issues FIFO reads and drives TXD.
// The slave side is the FIFO and system logic around it.
interface uart_tx_fifo_rd_if;
  logic       ena;
  logic       tx_fifo_empty;
  logic       tx_fifo_rden;
  logic [7:0] tx_fifo_rdata;
  logic       txd;
  logic       busy;
  logic       byte_done;

  modport master (
    input  ena, tx_fifo_empty, tx_fifo_rdata,
    output tx_fifo_rden, txd, busy, byte_done
  );

  modport slave (
    output ena, tx_fifo_empty, tx_fifo_rdata,
    input  tx_fifo_rden, txd, busy, byte_done
  );
endinterface

// File: rtl/uart_tx_fifo_rd.sv
// UART1 transmit serialiser. Drains the tx FIFO one byte per frame (normal,
// non-show-ahead read) and sends start, 8 data bits LSB first, optional
// parity and 1 or 2 stop bits on TXD.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line idle high, waiting for ena and a non-empty FIFO
// READ   | one-cycle FIFO read strobe
// LATCH  | capture read data, precompute parity, arm the start bit
// START  | start bit (low) for one bit period
// DATA   | 8 data bits, LSB first, one bit period each
// PARITY | parity bit for one bit period (only when parity is enabled)
// STOP   | stop bit(s) high; byte_done on the final clock
module uart_tx_fifo_rd #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_fifo_rd_if.master  bus
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_fifo_rd: CLK_FREQ/BAUD gives a bit period below 2 clocks");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_parity_check
    $error("uart_tx_fifo_rd: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_tx_fifo_rd: STOP_BITS must be 1 or 2");
  end

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          cnt_end;
  logic          more_data;

  assign cnt_end   = (cnt_q == CNT_LAST);
  assign more_data = bus.ena && !bus.tx_fifo_empty;

  // Next-state, bit timing and registered TXD value.
  // bit_q doubles as the stop-bit index while in STOP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (more_data) state_d = S_READ;
      end
      S_READ: begin
        txd_d   = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        shift_d = bus.tx_fifo_rdata;
        par_d   = (PARITY == 1) ? ~^bus.tx_fifo_rdata : ^bus.tx_fifo_rdata;
        cnt_d   = '0;
        bit_d   = '0;
        txd_d   = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        if (cnt_end) begin
          cnt_d   = '0;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY != 0) begin
              txd_d   = par_q;
              state_d = S_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_end) begin
          cnt_d   = '0;
          txd_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (cnt_end) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = more_data ? S_READ : S_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; an in-flight byte is dropped on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign bus.tx_fifo_rden = (state_q == S_READ);
  assign bus.txd          = txd_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.byte_done    = (state_q == S_STOP) && cnt_end && (bit_q == STOP_LAST);

endmodule

// File: tb/tb_uart_tx_fifo_rd.sv
// Directed bench for uart_tx_fifo_rd at DIV=10. Four instances cover
// no parity, even parity, odd parity and two stop bits.
module tb_uart_tx_fifo_rd;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [N-1:0] ena_v = '0;
  logic [N-1:0] empty_v, rden_v, txd_v, busy_v, bd_v;
  logic [7:0]   rdata_v [N] = '{default: 8'h00};
  logic [7:0]   mem [N][32];
  int           wr_ptr   [N] = '{default: 0};
  int           rd_ptr   [N] = '{default: 0};
  int           rden_cnt [N] = '{default: 0};
  int           uflow    [N] = '{default: 0};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int P = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam int S = (g == 3) ? 2 : 1;
    uart_tx_fifo_rd_if bus ();
    assign bus.ena           = ena_v[g];
    assign bus.tx_fifo_empty = empty_v[g];
    assign bus.tx_fifo_rdata = rdata_v[g];
    assign empty_v[g]        = (wr_ptr[g] == rd_ptr[g]);
    assign rden_v[g]         = bus.tx_fifo_rden;
    assign txd_v[g]          = bus.txd;
    assign busy_v[g]         = bus.busy;
    assign bd_v[g]           = bus.byte_done;
    uart_tx_fifo_rd #(
      .CLK_FREQ (1000000),
      .BAUD     (100000),
      .PARITY   (P),
      .STOP_BITS(S)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  // FIFO model: normal-mode read, data valid the cycle after rden.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rden_v[k]) begin
        rden_cnt[k] <= rden_cnt[k] + 1;
        if (wr_ptr[k] == rd_ptr[k]) begin
          uflow[k] <= uflow[k] + 1;
        end else begin
          rdata_v[k] <= mem[k][rd_ptr[k][4:0]];
          rd_ptr[k]  <= rd_ptr[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    mem[k][wr_ptr[k][4:0]] = d;
    wr_ptr[k] = wr_ptr[k] + 1;
  endtask

  // Waits for the start bit, then checks every clock of every bit period.
  // pbit < 0 means no parity bit; drop_at >= 0 lowers ena at that frame clock.
  task automatic check_frame(input int k, input logic [7:0] d, input int pbit,
                             input int sb, input int drop_at, input string tag,
                             output int wn, output logic busy_ok);
    logic       eb [12];
    int         nb;
    int         bd_n;
    int         bd_pos;
    int         idx;
    logic [9:0] v;
    eb[0] = 1'b0;
    for (int j = 0; j < 8; j++) eb[1+j] = d[j];
    nb = 9;
    if (pbit >= 0) begin
      eb[nb] = pbit[0];
      nb++;
    end
    for (int s = 0; s < sb; s++) begin
      eb[nb] = 1'b1;
      nb++;
    end
    wn      = 0;
    busy_ok = 1'b1;
    bd_n    = 0;
    bd_pos  = -1;
    do begin
      @(negedge clk);
      wn++;
      busy_ok = busy_ok & busy_v[k];
    end while (txd_v[k] !== 1'b0 && wn < 40);
    chk({tag, "_fall"}, 32'(txd_v[k]), 32'h0);
    if (txd_v[k] !== 1'b0) return;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 10; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        idx = b * 10 + c;
        if (idx == drop_at) ena_v[k] = 1'b0;
        v[c] = txd_v[k];
        busy_ok = busy_ok & busy_v[k];
        if (bd_v[k] === 1'b1) begin
          bd_n++;
          bd_pos = idx;
        end
      end
      chk($sformatf("%s_bit%0d", tag, b), 32'(v), eb[b] ? 32'h3FF : 32'h0);
    end
    chk({tag, "_done_cnt"}, bd_n, 1);
    chk({tag, "_done_pos"}, bd_pos, nb * 10 - 1);
  endtask

  logic [7:0] t2b [4] = '{8'hFF, 8'h7F, 8'hFF, 8'h7F};

  initial begin
    int   wn;
    int   n;
    int   cnt0;
    logic bok;
    logic all;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_txd",  32'(txd_v),  32'hF);
    chk("rst_busy", 32'(busy_v), 32'h0);
    chk("rst_done", 32'(bd_v),   32'h0);
    chk("rst_rden", 32'(rden_v), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single byte 0xA5, no parity
    ena_v[0] = 1'b1;
    push(0, 8'hA5);
    check_frame(0, 8'hA5, -1, 1, -1, "t1", wn, bok);
    chk("t1_latency", wn, 3);
    chk("t1_busy", 32'(bok), 32'h1);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy_v[0]), 32'h0);
    chk("t1_idle_txd", 32'(txd_v[0]), 32'h1);
    chk("t1_rden_cnt", rden_cnt[0], 1);

    // four bytes back to back
    for (int i = 0; i < 4; i++) push(0, t2b[i]);
    all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_frame(0, t2b[i], -1, 1, -1, $sformatf("t2_%0d", i), wn, bok);
      chk($sformatf("t2_gap%0d", i), wn, 3);
      all = all & bok;
    end
    chk("t2_busy", 32'(all), 32'h1);
    @(negedge clk);
    chk("t2_idle_busy", 32'(busy_v[0]), 32'h0);
    chk("t2_idle_txd", 32'(txd_v[0]), 32'h1);
    chk("t2_rden_cnt", rden_cnt[0], 5);

    // parity: even 0x07 -> 1, even 0x03 -> 0, odd 0x07 -> 0
    ena_v[1] = 1'b1;
    push(1, 8'h07);
    check_frame(1, 8'h07, 1, 1, -1, "t3_even07", wn, bok);
    @(negedge clk);
    chk("t3_even_idle", 32'(busy_v[1]), 32'h0);
    push(1, 8'h03);
    check_frame(1, 8'h03, 0, 1, -1, "t3_even03", wn, bok);
    ena_v[2] = 1'b1;
    push(2, 8'h07);
    check_frame(2, 8'h07, 0, 1, -1, "t3_odd07", wn, bok);

    // ena low holds off reads; ena dropped during data bit 3
    ena_v[0] = 1'b0;
    push(0, 8'h3C);
    push(0, 8'h45);
    cnt0 = rden_cnt[0];
    all  = 1'b1;
    repeat (30) begin
      @(negedge clk);
      all = all & txd_v[0] & ~busy_v[0];
    end
    chk("t4_hold_line", 32'(all), 32'h1);
    chk("t4_hold_rden", rden_cnt[0], cnt0);
    ena_v[0] = 1'b1;
    check_frame(0, 8'h3C, -1, 1, 45, "t4", wn, bok);
    all = 1'b1;
    repeat (20) begin
      @(negedge clk);
      all = all & txd_v[0] & ~busy_v[0];
    end
    chk("t4_after_line", 32'(all), 32'h1);
    chk("t4_rden_cnt", rden_cnt[0], cnt0 + 1);

    // reset during data bit 4 of 0x45, then resume with 0x96
    ena_v[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txd_v[0] !== 1'b0 && n < 40);
    chk("t5_fall", 32'(txd_v[0]), 32'h0);
    repeat (54) @(negedge clk);
    chk("t5_bit4", 32'(txd_v[0]), 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_txd",  32'(txd_v[0]), 32'h1);
    chk("t5_rst_busy", 32'(busy_v[0]), 32'h0);
    chk("t5_rst_done", 32'(bd_v[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push(0, 8'h96);
    check_frame(0, 8'h96, -1, 1, -1, "t5b", wn, bok);
    chk("t5b_latency", wn, 3);
    chk("t5_rden_cnt", rden_cnt[0], 8);

    // two stop bits
    ena_v[3] = 1'b1;
    push(3, 8'h81);
    check_frame(3, 8'h81, -1, 2, -1, "t6", wn, bok);
    chk("t6_latency", wn, 3);

    chk("underflow", uflow[0] + uflow[1] + uflow[2] + uflow[3], 0);
    chk("rden_cnt1", rden_cnt[1], 2);
    chk("rden_cnt2", rden_cnt[2], 1);
    chk("rden_cnt3", rden_cnt[3], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
